// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types and opcode constants for alu_arbiter
//
// Purpose: FSM state enum and ALU opcode encodings used by the arbiter top
//          and the shared ALU.
// Ports:   none (package).
// Macro:   ALU_ARBITER_MUL_EN adds the MUL state to the enum.

package alu_arbiter_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_MUL = 4'b1011;

`ifdef ALU_ARBITER_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    MUL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by both requesters
//
// Purpose: single-cycle ALU; shifts move b by a[4:0], lui places b[15:0]
//          in the upper half.
// Ports:   a_i, b_i  - 32-bit operands
//          aluc_i    - 4-bit opcode
//          r_o       - 32-bit result (modulo 2^32)

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  aluc_i,
  output logic [31:0] r_o
);

  always_comb begin
    r_o = a_i + b_i;
    // Bit 3 is a don't-care except where it separates srl from sra;
    // x011 therefore covers both sll encodings (0011 and 1011).
    casez (aluc_i)
      4'b?000: r_o = a_i + b_i;
      4'b?100: r_o = a_i - b_i;
      4'b?001: r_o = a_i & b_i;
      4'b?101: r_o = a_i | b_i;
      4'b?010: r_o = a_i ^ b_i;
      4'b?110: r_o = {b_i[15:0], 16'h0000};
      4'b?011: r_o = b_i << a_i[4:0];
      4'b0111: r_o = b_i >> a_i[4:0];
      4'b1111: r_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      default: r_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of one ALU
//
// Purpose: grants one of two requesters in IDLE, computes through a single
//          shared ALU and holds the registered response until consumed.
// Ports:   clk, rst                   - clock, synchronous active-high reset
//          req_valid[1:0]/req_ready   - per-requester handshake
//          req{0,1}_a/_b/_aluc        - per-requester operands and opcode
//          rsp_valid/rsp_ready        - response handshake
//          rsp_id, rsp_r, rsp_z       - owner, result, result-is-zero
// Macro:   ALU_ARBITER_MUL_EN - opcode 1011 becomes a 32-step shift-add
//          multiply sequenced through the shared ALU; otherwise it is sll.

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic        rsp_z
);

  localparam logic PRIO_BIT = 1'(PRIO_INIT);

  state_e      state_q;
  logic        last_grant_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic        rsp_z_q;
  logic [31:0] rsp_r_q;

  logic        grant;
  logic        accept;
  logic [1:0]  ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_aluc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;

`ifdef ALU_ARBITER_MUL_EN
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  step_q;
  logic [31:0] acc_d;
  logic        is_mul;
`endif

  // Contention goes to whoever was not granted last; a lone requester wins.
  always_comb begin
    grant = (&req_valid) ? ~last_grant_q : req_valid[1];
  end

  // Gated by rst so a reset cycle never looks like an accept to a requester.
  assign ready     = (state_q == IDLE && !rst) ?
                     (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign req_ready = ready;
  assign accept    = |ready;

  assign op_a    = grant ? req1_a    : req0_a;
  assign op_b    = grant ? req1_b    : req0_b;
  assign op_aluc = grant ? req1_aluc : req0_aluc;

  always_comb begin
    alu_a    = op_a;
    alu_b    = op_b;
    alu_aluc = op_aluc;
`ifdef ALU_ARBITER_MUL_EN
    // While multiplying, the ALU is borrowed as the accumulator adder.
    if (state_q == MUL) begin
      alu_a    = acc_q;
      alu_b    = mcand_q;
      alu_aluc = ALUC_ADD;
    end
`endif
  end

`ifdef ALU_ARBITER_MUL_EN
  assign is_mul = (op_aluc == ALUC_MUL);
  assign acc_d  = mplier_q[0] ? alu_r : acc_q;
`endif

  alu_arbiter_alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .aluc_i (alu_aluc),
    .r_o    (alu_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ~PRIO_BIT;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_r_q      <= '0;
`ifdef ALU_ARBITER_MUL_EN
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      step_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_grant_q <= grant;
            rsp_id_q     <= grant;
`ifdef ALU_ARBITER_MUL_EN
            if (is_mul) begin
              acc_q    <= '0;
              mcand_q  <= op_a;
              mplier_q <= op_b;
              step_q   <= '0;
              state_q  <= MUL;
            end else
`endif
            begin
              rsp_r_q     <= alu_r;
              rsp_z_q     <= (alu_r == 32'd0);
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
`ifdef ALU_ARBITER_MUL_EN
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + 5'd1;
          // Step 31 is the 32nd add; publish its result directly.
          if (step_q == 5'd31) begin
            rsp_r_q     <= acc_d;
            rsp_z_q     <= (acc_d == 32'd0);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_z     = rsp_z_q;

endmodule
